// File: rtl/wb_dma_rf_lite.sv
`default_nettype none
// ============================================================================
//  Module      : wb_dma_rf_lite
//  Description : DMA register file behind the WISHBONE slave stage. Holds the
//                global CSR/INT_MSK/INT_SRC and per-channel CSR, remaining
//                size and source/destination addresses. Tracks transfer
//                progress from engine decrement/error pulses and raises a
//                registered, masked interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_dma_rf_lite #(
    parameter int CH_NUM = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            slv_adr,
    input  logic [31:0]            slv_dout,
    input  logic                   slv_re,
    input  logic                   slv_we,
    output logic [31:0]            slv_din,
    input  logic [CH_NUM-1:0]      de_dec,
    input  logic [CH_NUM-1:0]      de_err,
    output logic [CH_NUM-1:0]      ch_en,
    output logic [12*CH_NUM-1:0]   ch_sz,
    output logic [32*CH_NUM-1:0]   ch_a0,
    output logic [32*CH_NUM-1:0]   ch_a1,
    output logic                   pause_o,
    output logic                   inta_o
);

    // Register index within a 32-byte window (slv_adr[4:2])
    localparam logic [2:0] c_GLB_CSR = 3'd0;
    localparam logic [2:0] c_GLB_MSK = 3'd1;
    localparam logic [2:0] c_GLB_SRC = 3'd2;
    localparam logic [2:0] c_CH_CSR  = 3'd0;
    localparam logic [2:0] c_CH_SZ   = 3'd1;
    localparam logic [2:0] c_CH_A0   = 3'd2;
    localparam logic [2:0] c_CH_A1   = 3'd3;

    // Global registers
    logic                   r_pause;
    logic [CH_NUM-1:0]      r_int_msk;
    logic [CH_NUM-1:0]      r_int_src;
    logic                   r_inta;

    // Per-channel registers
    logic [CH_NUM-1:0]      r_en;
    logic [CH_NUM-1:0]      r_done;
    logic [CH_NUM-1:0]      r_err;
    logic [CH_NUM-1:0]      r_ine_done;
    logic [CH_NUM-1:0]      r_ine_err;
    logic [12*CH_NUM-1:0]   r_sz;
    logic [32*CH_NUM-1:0]   r_a0;
    logic [32*CH_NUM-1:0]   r_a1;

    // Decode: [7:5] selects the window (0 = global, i+1 = channel i)
    logic [2:0]             w_blk;
    logic [2:0]             w_reg;
    logic                   w_glb;
    logic [CH_NUM-1:0]      w_ch_sel;
    logic                   w_unused_adr;

    // Per-channel write strobes and hardware events
    logic [CH_NUM-1:0]      w_wr_csr;
    logic [CH_NUM-1:0]      w_wr_sz;
    logic [CH_NUM-1:0]      w_wr_a0;
    logic [CH_NUM-1:0]      w_wr_a1;
    logic [CH_NUM-1:0]      w_err_evt;
    logic [CH_NUM-1:0]      w_dec_ok;
    logic [CH_NUM-1:0]      w_done_evt;
    logic [CH_NUM-1:0]      w_src_set;
    logic [CH_NUM-1:0]      w_src_clr;
    logic [31:0]            w_rdata;

    assign w_blk        = slv_adr[7:5];
    assign w_reg        = slv_adr[4:2];
    assign w_glb        = (w_blk == 3'd0);
    assign w_unused_adr = &{1'b0, slv_adr[31:8], slv_adr[1:0]};

    // Channel window select, write strobes and engine events
    always_comb begin
        w_ch_sel   = '0;
        w_wr_csr   = '0;
        w_wr_sz    = '0;
        w_wr_a0    = '0;
        w_wr_a1    = '0;
        w_err_evt  = '0;
        w_dec_ok   = '0;
        w_done_evt = '0;
        w_src_set  = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            w_ch_sel[i]   = (w_blk == 3'(i + 1));
            w_wr_csr[i]   = slv_we & w_ch_sel[i] & (w_reg == c_CH_CSR);
            w_wr_sz[i]    = slv_we & w_ch_sel[i] & (w_reg == c_CH_SZ);
            w_wr_a0[i]    = slv_we & w_ch_sel[i] & (w_reg == c_CH_A0);
            w_wr_a1[i]    = slv_we & w_ch_sel[i] & (w_reg == c_CH_A1);
            // An error freezes the count, so it also suppresses the decrement
            w_err_evt[i]  = r_en[i] & de_err[i];
            w_dec_ok[i]   = r_en[i] & de_dec[i] & ~w_err_evt[i]
                            & (r_sz[12*i +: 12] != 12'd0);
            w_done_evt[i] = w_dec_ok[i] & (r_sz[12*i +: 12] == 12'd1);
            w_src_set[i]  = (w_done_evt[i] & r_ine_done[i])
                            | (w_err_evt[i] & r_ine_err[i]);
        end
    end

    assign w_src_clr = (slv_we && w_glb && (w_reg == c_GLB_SRC))
                       ? slv_dout[CH_NUM-1:0] : '0;

    // Read data multiplexer; unmapped offsets and unused bits return 0
    always_comb begin
        w_rdata = '0;
        if (w_glb) begin
            case (w_reg)
                c_GLB_CSR: w_rdata[0]          = r_pause;
                c_GLB_MSK: w_rdata[CH_NUM-1:0] = r_int_msk;
                c_GLB_SRC: w_rdata[CH_NUM-1:0] = r_int_src;
                default:   w_rdata             = '0;
            endcase
        end
        for (int i = 0; i < CH_NUM; i++) begin
            if (w_ch_sel[i]) begin
                case (w_reg)
                    c_CH_CSR: w_rdata[4:0]  = {r_ine_err[i], r_ine_done[i],
                                               r_err[i], r_done[i], r_en[i]};
                    c_CH_SZ:  w_rdata[11:0] = r_sz[12*i +: 12];
                    c_CH_A0:  w_rdata       = r_a0[32*i +: 32];
                    c_CH_A1:  w_rdata       = r_a1[32*i +: 32];
                    default:  w_rdata       = '0;
                endcase
            end
        end
    end

    // Read data register: loaded on the read strobe, held otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slv_din <= '0;
        end else if (slv_re) begin
            slv_din <= w_rdata;
        end
    end

    // Global CSR, interrupt mask/source and registered interrupt output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pause   <= 1'b0;
            r_int_msk <= '0;
            r_int_src <= '0;
            r_inta    <= 1'b0;
        end else begin
            if (slv_we && w_glb && (w_reg == c_GLB_CSR)) begin
                r_pause <= slv_dout[0];
            end
            if (slv_we && w_glb && (w_reg == c_GLB_MSK)) begin
                r_int_msk <= slv_dout[CH_NUM-1:0];
            end
            // A new source event beats a same-cycle write-1-to-clear
            r_int_src <= (r_int_src & ~w_src_clr) | w_src_set;
            r_inta    <= |(r_int_src & r_int_msk);
        end
    end

    // Per-channel state: hardware completion/error overrides software EN/DONE/ERR
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_en       <= '0;
            r_done     <= '0;
            r_err      <= '0;
            r_ine_done <= '0;
            r_ine_err  <= '0;
            r_sz       <= '0;
            r_a0       <= '0;
            r_a1       <= '0;
        end else begin
            for (int i = 0; i < CH_NUM; i++) begin
                if (w_err_evt[i]) begin
                    r_en[i]  <= 1'b0;
                    r_err[i] <= 1'b1;
                end else if (w_done_evt[i]) begin
                    r_en[i]   <= 1'b0;
                    r_done[i] <= 1'b1;
                end else if (w_wr_csr[i]) begin
                    r_en[i] <= slv_dout[0];
                    if (slv_dout[0]) begin
                        r_done[i] <= 1'b0;
                        r_err[i]  <= 1'b0;
                    end
                end
                if (w_wr_csr[i]) begin
                    r_ine_done[i] <= slv_dout[3];
                    r_ine_err[i]  <= slv_dout[4];
                end
                // Software load of the count beats an engine decrement
                if (w_wr_sz[i]) begin
                    r_sz[12*i +: 12] <= slv_dout[11:0];
                end else if (w_dec_ok[i]) begin
                    r_sz[12*i +: 12] <= r_sz[12*i +: 12] - 12'd1;
                end
                if (w_wr_a0[i]) begin
                    r_a0[32*i +: 32] <= slv_dout;
                end
                if (w_wr_a1[i]) begin
                    r_a1[32*i +: 32] <= slv_dout;
                end
            end
        end
    end

    assign ch_en   = r_en;
    assign ch_sz   = r_sz;
    assign ch_a0   = r_a0;
    assign ch_a1   = r_a1;
    assign pause_o = r_pause;
    assign inta_o  = r_inta;

endmodule
`default_nettype wire

// File: tb/tb_wb_dma_rf_lite.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_dma_rf_lite
//  Description : Self-checking bench for wb_dma_rf_lite: directed vector
//                table, randomized traffic against a register-level model,
//                reduced-channel instance and asynchronous reset corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_dma_rf_lite;

    localparam int CH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [31:0]       slv_adr = '0;
    logic [31:0]       slv_dout = '0;
    logic              slv_re = 1'b0;
    logic              slv_we = 1'b0;
    logic [CH-1:0]     de_dec = '0;
    logic [CH-1:0]     de_err = '0;
    logic [31:0]       slv_din;
    logic [CH-1:0]     ch_en;
    logic [12*CH-1:0]  ch_sz;
    logic [32*CH-1:0]  ch_a0;
    logic [32*CH-1:0]  ch_a1;
    logic              pause_o;
    logic              inta_o;

    // Two-channel instance sharing the register bus
    logic [1:0]        de_dec2 = '0;
    logic [1:0]        de_err2 = '0;
    logic [31:0]       din2;
    logic [1:0]        d2_unused_en;
    logic [23:0]       d2_unused_sz;
    logic [63:0]       d2_unused_a0;
    logic [63:0]       d2_unused_a1;
    logic              d2_unused_pause;
    logic              d2_unused_inta;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_dma_rf_lite #(.CH_NUM(CH)) u_dut (
        .clk(clk), .rst(rst), .slv_adr(slv_adr), .slv_dout(slv_dout),
        .slv_re(slv_re), .slv_we(slv_we), .slv_din(slv_din),
        .de_dec(de_dec), .de_err(de_err), .ch_en(ch_en), .ch_sz(ch_sz),
        .ch_a0(ch_a0), .ch_a1(ch_a1), .pause_o(pause_o), .inta_o(inta_o)
    );

    wb_dma_rf_lite #(.CH_NUM(2)) u_dut2 (
        .clk(clk), .rst(rst), .slv_adr(slv_adr), .slv_dout(slv_dout),
        .slv_re(slv_re), .slv_we(slv_we), .slv_din(din2),
        .de_dec(de_dec2), .de_err(de_err2), .ch_en(d2_unused_en),
        .ch_sz(d2_unused_sz), .ch_a0(d2_unused_a0), .ch_a1(d2_unused_a1),
        .pause_o(d2_unused_pause), .inta_o(d2_unused_inta)
    );

    // ---------------- reference model (register-level view) ----------------
    bit          m_pause;
    bit [CH-1:0] m_msk;
    bit [CH-1:0] m_src;
    bit          m_inta;
    logic [31:0] m_din;
    bit          m_en[CH];
    bit          m_done[CH];
    bit          m_err[CH];
    bit          m_ined[CH];
    bit          m_inee[CH];
    int          m_sz[CH];
    logic [31:0] m_a0[CH];
    logic [31:0] m_a1[CH];

    task automatic model_reset();
        m_pause = 0; m_msk = '0; m_src = '0; m_inta = 0; m_din = '0;
        for (int c = 0; c < CH; c++) begin
            m_en[c] = 0; m_done[c] = 0; m_err[c] = 0; m_ined[c] = 0;
            m_inee[c] = 0; m_sz[c] = 0; m_a0[c] = '0; m_a1[c] = '0;
        end
    endtask

    function automatic logic [31:0] model_read(input int a);
        int c, r;
        if (a == 0)  return {31'd0, m_pause};
        if (a == 4)  return 32'(m_msk);
        if (a == 8)  return 32'(m_src);
        if (a < 32 || a >= 32 + 32 * CH) return 32'd0;
        c = (a - 32) / 32;
        r = (a - 32) % 32;
        case (r)
            0:  return 32'(m_en[c] + 2 * m_done[c] + 4 * m_err[c]
                           + 8 * m_ined[c] + 16 * m_inee[c]);
            4:  return 32'(m_sz[c]);
            8:  return m_a0[c];
            12: return m_a1[c];
            default: return 32'd0;
        endcase
    endfunction

    // One clock of the register file: read sees the old state, then
    // hardware events, software writes and event/write precedence.
    task automatic model_step(input bit we, input bit re, input logic [31:0] adr,
                              input logic [31:0] dout, input logic [CH-1:0] dec,
                              input logic [CH-1:0] err);
        int a;
        bit nxt_inta;
        bit hw[CH];
        bit hen[CH], hdone[CH], herr[CH];
        bit [CH-1:0] setb;
        a = int'(adr[7:0]) / 4 * 4;
        nxt_inta = |(m_src & m_msk);
        setb = '0;
        if (re) m_din = model_read(a);
        for (int c = 0; c < CH; c++) begin
            bit erh, fin;
            erh = m_en[c] && err[c];
            fin = m_en[c] && dec[c] && !erh && m_sz[c] == 1;
            if (m_en[c] && dec[c] && !erh && m_sz[c] > 0) m_sz[c] = m_sz[c] - 1;
            if ((erh && m_inee[c]) || (fin && m_ined[c])) setb[c] = 1'b1;
            hen[c] = m_en[c]; hdone[c] = m_done[c]; herr[c] = m_err[c];
            if (erh) begin hen[c] = 0; herr[c] = 1; end
            else if (fin) begin hen[c] = 0; hdone[c] = 1; end
            hw[c] = erh || fin;
        end
        if (we) begin
            if (a == 0)      m_pause = dout[0];
            else if (a == 4) m_msk = dout[CH-1:0];
            else if (a == 8) m_src = m_src & ~dout[CH-1:0];
            else if (a >= 32 && a < 32 + 32 * CH) begin
                int c, r;
                c = (a - 32) / 32;
                r = (a - 32) % 32;
                if (r == 0) begin
                    m_en[c] = dout[0]; m_ined[c] = dout[3]; m_inee[c] = dout[4];
                    if (dout[0]) begin m_done[c] = 0; m_err[c] = 0; end
                end
                else if (r == 4)  m_sz[c] = int'(dout[11:0]);
                else if (r == 8)  m_a0[c] = dout;
                else if (r == 12) m_a1[c] = dout;
            end
        end
        for (int c = 0; c < CH; c++) begin
            if (hw[c]) begin m_en[c] = hen[c]; m_done[c] = hdone[c]; m_err[c] = herr[c]; end
        end
        m_src  = m_src | setb;
        m_inta = nxt_inta;
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        logic [CH-1:0]    e_en;
        logic [12*CH-1:0] e_sz;
        logic [32*CH-1:0] e_a0, e_a1;
        for (int c = 0; c < CH; c++) begin
            e_en[c]          = m_en[c];
            e_sz[12*c +: 12] = 12'(m_sz[c]);
            e_a0[32*c +: 32] = m_a0[c];
            e_a1[32*c +: 32] = m_a1[c];
        end
        chk("slv_din", 128'(slv_din), 128'(m_din));
        chk("ch_en",   128'(ch_en),   128'(e_en));
        chk("ch_sz",   128'(ch_sz),   128'(e_sz));
        chk("ch_a0",   128'(ch_a0),   128'(e_a0));
        chk("ch_a1",   128'(ch_a1),   128'(e_a1));
        chk("pause_o", 128'(pause_o), 128'(m_pause));
        chk("inta_o",  128'(inta_o),  128'(m_inta));
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_din"},  128'(slv_din), 128'd0);
        chk({nm, "_en"},   128'(ch_en),   128'd0);
        chk({nm, "_sz"},   128'(ch_sz),   128'd0);
        chk({nm, "_a0"},   128'(ch_a0),   128'd0);
        chk({nm, "_a1"},   128'(ch_a1),   128'd0);
        chk({nm, "_ctl"},  128'({pause_o, inta_o}), 128'd0);
    endtask

    // Drive one cycle, advance the model, sample #1 after the edge
    task automatic apply(input bit we, input bit re, input logic [31:0] adr,
                         input logic [31:0] dout, input logic [CH-1:0] dec,
                         input logic [CH-1:0] err);
        slv_we = we; slv_re = re; slv_adr = adr; slv_dout = dout;
        de_dec = dec; de_err = err;
        model_step(we, re, adr, dout, dec, err);
        @(posedge clk);
        #1;
        chk_model();
        slv_we = 0; slv_re = 0; de_dec = '0; de_err = '0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          we;
        bit          re;
        logic [7:0]  adr;
        logic [31:0] dout;
        logic [3:0]  dec;
        logic [3:0]  err;
        logic [31:0] x_din;
        logic [3:0]  x_en;
        logic [11:0] x_sz0;
        bit          x_inta;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input bit we, input bit re, input logic [7:0] adr,
                                input logic [31:0] dout, input logic [3:0] dec,
                                input logic [3:0] err, input logic [31:0] x_din,
                                input logic [3:0] x_en, input logic [11:0] x_sz0,
                                input bit x_inta);
        vec_t v;
        v.we = we; v.re = re; v.adr = adr; v.dout = dout; v.dec = dec; v.err = err;
        v.x_din = x_din; v.x_en = x_en; v.x_sz0 = x_sz0; v.x_inta = x_inta;
        return v;
    endfunction

    function automatic logic [31:0] rnd_adr();
        logic [31:0] r;
        logic [7:0]  a;
        int          k;
        k = int'($urandom_range(0, 9));
        if (k < 2) a = 8'(4 * $urandom_range(0, 3));
        else a = 8'(32 * $urandom_range(1, CH + 1)
                    + 4 * ((k < 8) ? $urandom_range(0, 3) : $urandom_range(4, 7)));
        r = $urandom();
        r[7:0] = a | 8'($urandom_range(0, 3));
        return r;
    endfunction

    initial begin
        // Reset state
        model_reset();
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;

        //             we    re    adr    dout          dec   err    din           en    sz0     inta
        tbl.push_back(mk(1'b0, 1'b1, 8'h00, 32'h0,        4'h0, 4'h0, 32'h0,        4'h0, 12'd0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 8'h04, 32'h0,        4'h0, 4'h0, 32'h0,        4'h0, 12'd0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 8'h08, 32'h0,        4'h0, 4'h0, 32'h0,        4'h0, 12'd0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 8'h20, 32'h0,        4'h0, 4'h0, 32'h0,        4'h0, 12'd0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 8'h24, 32'h0,        4'h0, 4'h0, 32'h0,        4'h0, 12'd0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 8'h48, 32'hDEADBEEF, 4'h0, 4'h0, 32'h0,        4'h0, 12'd0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 8'h48, 32'h0,        4'h0, 4'h0, 32'hDEADBEEF, 4'h0, 12'd0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 8'h24, 32'h3,        4'h0, 4'h0, 32'hDEADBEEF, 4'h0, 12'd3, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 8'h04, 32'h1,        4'h0, 4'h0, 32'hDEADBEEF, 4'h0, 12'd3, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 8'h20, 32'h9,        4'h0, 4'h0, 32'hDEADBEEF, 4'h1, 12'd3, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 8'h00, 32'h0,        4'h1, 4'h0, 32'hDEADBEEF, 4'h1, 12'd2, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 8'h00, 32'h0,        4'h1, 4'h0, 32'hDEADBEEF, 4'h1, 12'd1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 8'h00, 32'h0,        4'h1, 4'h0, 32'hDEADBEEF, 4'h0, 12'd0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 8'h20, 32'h0,        4'h0, 4'h0, 32'h0A,       4'h0, 12'd0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, 8'h08, 32'h0,        4'h0, 4'h0, 32'h1,        4'h0, 12'd0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 8'h08, 32'h1,        4'h0, 4'h0, 32'h1,        4'h0, 12'd0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 8'h00, 32'h0,        4'h0, 4'h0, 32'h1,        4'h0, 12'd0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 8'h00, 32'h0,        4'h1, 4'h0, 32'h1,        4'h0, 12'd0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 8'h24, 32'h5,        4'h0, 4'h0, 32'h1,        4'h0, 12'd5, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 8'h00, 32'h0,        4'h1, 4'h0, 32'h1,        4'h0, 12'd5, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 8'h64, 32'h1,        4'h0, 4'h0, 32'h1,        4'h0, 12'd5, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 8'h60, 32'h19,       4'h0, 4'h0, 32'h1,        4'h4, 12'd5, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 8'h00, 32'h0,        4'h4, 4'h4, 32'h1,        4'h0, 12'd5, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 8'h60, 32'h0,        4'h0, 4'h0, 32'h1C,       4'h0, 12'd5, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 8'h64, 32'h0,        4'h0, 4'h0, 32'h1,        4'h0, 12'd5, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 8'h08, 32'h0,        4'h0, 4'h0, 32'h4,        4'h0, 12'd5, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 8'h44, 32'h1,        4'h0, 4'h0, 32'h4,        4'h0, 12'd5, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 8'h40, 32'h9,        4'h0, 4'h0, 32'h4,        4'h2, 12'd5, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 8'h08, 32'h2,        4'h2, 4'h0, 32'h4,        4'h0, 12'd5, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 8'h08, 32'h0,        4'h0, 4'h0, 32'h6,        4'h0, 12'd5, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 8'hA0, 32'hFFFFFFFF, 4'h0, 4'h0, 32'h6,        4'h0, 12'd5, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 8'hA0, 32'h0,        4'h0, 4'h0, 32'h0,        4'h0, 12'd5, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 8'h0C, 32'h0,        4'h0, 4'h0, 32'h0,        4'h0, 12'd5, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 8'h00, 32'h1,        4'h0, 4'h0, 32'h0,        4'h0, 12'd5, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 8'h00, 32'h0,        4'h0, 4'h0, 32'h1,        4'h0, 12'd5, 1'b0));

        foreach (tbl[i]) begin
            apply(tbl[i].we, tbl[i].re, {24'd0, tbl[i].adr}, tbl[i].dout,
                  tbl[i].dec, tbl[i].err);
            chk($sformatf("row%0d_din", i),  128'(slv_din),      128'(tbl[i].x_din));
            chk($sformatf("row%0d_en", i),   128'(ch_en),        128'(tbl[i].x_en));
            chk($sformatf("row%0d_sz0", i),  128'(ch_sz[11:0]),  128'(tbl[i].x_sz0));
            chk($sformatf("row%0d_inta", i), 128'(inta_o),       128'(tbl[i].x_inta));
        end
        chk("ch1_a0_port", 128'(ch_a0[63:32]), 128'(32'hDEADBEEF));
        chk("pause_port",  128'(pause_o),      128'd1);

        // Two-channel instance: channel-2 window is unimplemented there
        apply(1'b1, 1'b0, 32'h60, 32'hFFFFFFFF, 4'h0, 4'h0);
        apply(1'b0, 1'b1, 32'h60, 32'h0, 4'h0, 4'h0);
        chk("ch2_win_2ch", 128'(din2), 128'd0);

        // Hardware done beats a same-cycle software CSR write (ch3)
        apply(1'b1, 1'b0, 32'h84, 32'h1, 4'h0, 4'h0);
        apply(1'b1, 1'b0, 32'h80, 32'h1, 4'h0, 4'h0);
        apply(1'b1, 1'b0, 32'h80, 32'h19, 4'h8, 4'h0);
        apply(1'b0, 1'b1, 32'h80, 32'h0, 4'h0, 4'h0);
        chk("hw_vs_csr", 128'(slv_din), 128'(32'h1A));

        // Software size load beats a same-cycle decrement (ch0)
        apply(1'b1, 1'b0, 32'h24, 32'h7, 4'h0, 4'h0);
        apply(1'b1, 1'b0, 32'h20, 32'h1, 4'h0, 4'h0);
        apply(1'b1, 1'b0, 32'h24, 32'h9, 4'h1, 4'h0);
        chk("sz_wr_vs_dec", 128'(ch_sz[11:0]), 128'd9);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int          k;
            logic [31:0] d;
            logic [CH-1:0] dc, er;
            k  = int'($urandom_range(0, 3));
            d  = ($urandom_range(0, 2) == 0) ? $urandom() : 32'($urandom_range(0, 31));
            dc = CH'($urandom()) & CH'($urandom());
            er = ($urandom_range(0, 15) == 0) ? CH'($urandom()) : '0;
            apply(k == 1 || k == 3, k == 2, rnd_adr(), d, dc, er);
        end

        // Reset in the middle of a pending read
        apply(1'b1, 1'b0, 32'h48, 32'hDEADBEEF, 4'h0, 4'h0);
        apply(1'b0, 1'b1, 32'h48, 32'h0, 4'h0, 4'h0);
        chk("pre_rst_rd", 128'(slv_din), 128'(32'hDEADBEEF));
        @(posedge clk);
        #1;
        slv_re = 1'b1; slv_adr = 32'h48;
        #3;
        rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(posedge clk);
        #1;
        chk("rst_pending_rd", 128'(slv_din), 128'd0);
        @(negedge clk);
        slv_re = 1'b0;
        rst = 1'b1;
        model_reset();
        apply(1'b0, 1'b1, 32'h48, 32'h0, 4'h0, 4'h0);
        apply(1'b0, 1'b1, 32'h20, 32'h0, 4'h0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
